fifo_out_serializer: RTL
========================

# fifo_out_serializer

Width-down converter that drains command words from the output-side sync FIFO master port and emits them as narrow beats toward the host-facing link. Each accepted IN_WIDTH word is sent as RATIO = IN_WIDTH/OUT_WIDTH beats, least-significant slice first, and the final beat is flagged with m_last. Both sides use the same valid/ready handshake as the FIFO. Back-to-back words stream with no bubble.

## Interface

Parameters:

- IN_WIDTH, 32, width of a command word from the FIFO. Must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 8, beat width on the link side.
- RATIO (localparam), IN_WIDTH/OUT_WIDTH, beats per word. Legal range is 1..256.
- CNT_W (localparam), max(1, clog2(RATIO)), beat-counter width.

Ports:

- clk, input, 1, single clock; all logic on posedge.
- resetb, input, 1, asynchronous, active-low reset.
- s_valid, input, 1, word available from the FIFO master port.
- s_ready, output, 1, serializer can accept a word this cycle.
- s_data, input, IN_WIDTH, word from the FIFO.
- m_valid, output, 1, beat valid on the link.
- m_ready, input, 1, link accepts the beat.
- m_data, output, OUT_WIDTH, beat payload.
- m_last, output, 1, marks the final beat of a word.

## Operation

- Handshakes:
  - s_hs = s_valid & s_ready.
  - m_hs = m_valid & m_ready.
- State machine has two states, IDLE and SEND, held in a registered flag.
  - IDLE: m_valid = 0. s_ready = 1.
  - IDLE -> SEND on s_hs. The shift register loads s_data and beat_cnt is set to 0.
  - SEND: m_valid = 1. m_data = shreg[OUT_WIDTH-1:0]. m_last = (beat_cnt == RATIO-1).
  - SEND, m_hs with beat_cnt < RATIO-1: shreg shifts right by OUT_WIDTH with zero fill, and beat_cnt increments by 1.
  - SEND, m_hs on the last beat with s_valid = 1: the new word is accepted in the same cycle. shreg reloads, beat_cnt goes to 0, and the state stays SEND.
  - SEND, m_hs on the last beat with s_valid = 0: the state goes to IDLE.
- s_ready = IDLE | (SEND & m_last & m_ready). This is combinational from registered state plus m_ready; there is no path from s_valid to s_ready.
- Stall: while m_valid = 1 and m_ready = 0, m_data, m_last, shreg and beat_cnt hold.
  - Once asserted, m_valid does not drop until m_hs.
- beat_cnt never exceeds RATIO-1 and never wraps.
  - For RATIO = 1, m_last is constant 1 in SEND and the block acts as a one-deep register slice.
- Beat order: beat k carries s_data[(k+1)*OUT_WIDTH-1 : k*OUT_WIDTH].

## Timing

- Reset values (asserted asynchronously on resetb low):
  - state = IDLE, m_valid = 0, m_last = 0, m_data = 0.
  - shreg = 0, beat_cnt = 0.
  - s_ready = 1, since it is combinational from IDLE.
- Latency: the first beat of a word appears on m_valid one cycle after its s_hs.
- Throughput: one word per RATIO cycles when m_ready is held at 1 and s_valid is continuous. There are no idle cycles between words.
- Reset asserted mid-word: the partially sent word is discarded and no further beats are emitted. After release the block starts in IDLE.
- A word is accepted only on the cycle its last predecessor beat handshakes, or while in IDLE. No word is ever overwritten.

## Test plan

- Single word: reset, then s_data = 0x44332211 for one cycle with m_ready = 1.
  - m_data must be 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles.
  - m_last = 1 only on 0x44. m_valid then drops to 0.
- Back-to-back: stream 0xA3A2A1A0 and 0xB3B2B1B0 with m_ready = 1.
  - The bench must see 8 consecutive valid beats with no gap.
  - s_ready pulses high on the cycle of beat 0xA3.
- Backpressure: hold m_ready = 0 for 5 cycles during beat 2 of 0x0D0C0B0A.
  - m_data stays 0x0C and m_valid stays 1 throughout, and s_ready = 0.
  - Transmission resumes with 0x0D, m_last = 1.
- Random stalls: 200 random words with random s_valid and m_ready.
  - The reassembled beats must equal the input words in order.
  - Beat count must equal 4 × word count, and m_last must appear every 4th beat.
- Mid-word reset: assert resetb = 0 after beat 1 of 0xDEADBEEF.
  - m_valid = 0, m_data = 0 and s_ready = 1 immediately.
  - The next word sent after reset serializes correctly from beat 0.
- RATIO = 1 build (IN_WIDTH = OUT_WIDTH = 8): stream 0x01..0x10.
  - Each byte appears once with m_last = 1.
  - At full throughput there are no bubbles.

Source files
------------

// File: rtl/fifo_out_serializer.sv
// fifo_out_serializer
// Width-down converter: drains IN_WIDTH command words from the output-side
// FIFO and emits them as RATIO narrow beats, least-significant slice first,
// flagging the final beat of each word with m_last. A new word is taken on
// the same cycle the previous word's last beat handshakes, so a continuous
// stream has no bubbles.

module fifo_out_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]    beat_cnt;
    logic                last_q;
    logic [CNT_W-1:0]    next_cnt;
    logic                s_hs;

    assign next_cnt = beat_cnt + CNT_W'(1);

    // Outputs come straight from registered state; only s_ready looks at
    // m_ready so the last beat and the next word can handshake together.
    assign m_valid = (state == SEND);
    assign m_data  = shreg[OUT_WIDTH-1:0];
    assign m_last  = last_q;
    assign s_ready = (state == IDLE) | ((state == SEND) & last_q & m_ready);
    assign s_hs    = s_valid & s_ready;

    // Serializer state machine: load a word, shift out one slice per beat
    // handshake, and either reload or fall back to IDLE after the last beat.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            shreg    <= '0;
            beat_cnt <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_hs) begin
                        state    <= SEND;
                        shreg    <= s_data;
                        beat_cnt <= '0;
                        last_q   <= (RATIO == 1);
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        if (beat_cnt != LAST_CNT) begin
                            shreg    <= shreg >> OUT_WIDTH;
                            beat_cnt <= next_cnt;
                            last_q   <= (next_cnt == LAST_CNT);
                        end else if (s_valid) begin
                            shreg    <= s_data;
                            beat_cnt <= '0;
                            last_q   <= (RATIO == 1);
                        end else begin
                            state    <= IDLE;
                            shreg    <= '0;
                            beat_cnt <= '0;
                            last_q   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    shreg    <= '0;
                    beat_cnt <= '0;
                    last_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
